// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues in-order memory requests, buffers returned words
// in a small FIFO for decode, and squashes in-flight fetches on an execute-stage redirect.
module fetch_queue #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallD,
  output logic        InstrValidD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D
);

  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   instr_buf [DEPTH];
  logic [31:0]   pc_buf    [DEPTH];

  logic          handshake;
  logic          push;
  logic          pop;
  logic [CW:0]   committed;
  logic [31:0]   target;

  assign target    = PCTargetE & 32'hFFFF_FFFC;
  // FIFO slots are reserved at request time so a response always has room.
  assign committed = {1'b0, occupancy} + {1'b0, outstanding};

  assign imem_req_valid = !rst && !PCSrcE
                       && (outstanding < CW'(MAX_OUTSTANDING))
                       && (committed < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;

  assign handshake = imem_req_valid && imem_req_ready;
  assign push      = !rst && !PCSrcE && imem_rsp_valid && (drop_cnt == '0);
  assign pop       = !rst && !PCSrcE && InstrValidD && !StallD;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      occupancy   <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (PCSrcE) begin
      // Everything still in flight belongs to the squashed path.
      fetch_pc    <= target;
      rsp_pc      <= target;
      occupancy   <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      outstanding <= outstanding - CW'(imem_rsp_valid);
      drop_cnt    <= outstanding - CW'(imem_rsp_valid);
    end else begin
      if (handshake) fetch_pc <= fetch_pc + 32'd4;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        rsp_pc <= rsp_pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      outstanding <= outstanding + CW'(handshake) - CW'(imem_rsp_valid);
      occupancy   <= occupancy + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_buf[wr_ptr] <= imem_rsp_data;
      pc_buf[wr_ptr]    <= rsp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) assert (occupancy < CW'(DEPTH));
  end

  always_comb begin
    InstrValidD = (occupancy != '0);
    InstrD      = NOP;
    PCD         = 32'h0;
    PCPlus4D    = 32'h0;
    if (InstrValidD) begin
      InstrD   = instr_buf[rd_ptr];
      PCD      = pc_buf[rd_ptr];
      PCPlus4D = pc_buf[rd_ptr] + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios followed by random traffic, checked against
// an in-order program-stream model and a queue-based memory.
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallD;
  logic        InstrValidD;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;

  fetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
    .InstrValidD(InstrValidD), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          rsp_mode = 1;  // 0 random, 1 eager, 2 withhold
  logic [31:0] pend_addr[$];
  int          pend_cyc[$];
  logic [31:0] model_fetch;
  logic [31:0] exp_pc;
  int          model_out;
  bit          prev_hold = 0;
  logic [31:0] prev_instr, prev_pcd;
  int          pops = 0;

  function automatic logic [31:0] word(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h0000_00A0;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sample_checks();
    if (rst) begin
      check32("req_valid_in_reset", 32'(imem_req_valid), 32'd0);
    end else begin
      check32("req_addr", imem_req_addr, model_fetch);
      if (PCSrcE) check32("req_valid_on_redirect", 32'(imem_req_valid), 32'd0);
      if (imem_req_valid) check32("outstanding_limit", 32'(model_out < MAX_OUT), 32'd1);
      if (prev_hold) begin
        check32("stall_valid", 32'(InstrValidD), 32'd1);
        check32("stall_instr", InstrD, prev_instr);
        check32("stall_pcd", PCD, prev_pcd);
      end
      if (InstrValidD) begin
        check32("pcd", PCD, exp_pc);
        check32("instr", InstrD, word(exp_pc));
        check32("pcplus4", PCPlus4D, exp_pc + 32'd4);
      end else begin
        check32("empty_instr", InstrD, 32'h0000_0013);
        check32("empty_pcd", PCD, 32'h0);
        check32("empty_pcplus4", PCPlus4D, 32'h0);
      end
    end
  endtask

  // One clock: drive memory response, sample, then advance the model at the edge.
  task automatic cycle();
    bit hs, pp;
    if (!rst && pend_addr.size() > 0 && pend_cyc[0] < cyc &&
        (rsp_mode == 1 || (rsp_mode == 0 && $urandom_range(0, 2) != 0))) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word(pend_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    sample_checks();
    hs = imem_req_valid && imem_req_ready;
    pp = InstrValidD && !StallD && !PCSrcE && !rst;
    prev_hold  = !rst && StallD && !PCSrcE && InstrValidD;
    prev_instr = InstrD;
    prev_pcd   = PCD;
    @(posedge clk);
    if (rst) begin
      model_fetch = RESET_PC;
      exp_pc      = RESET_PC;
      model_out   = 0;
      pend_addr.delete();
      pend_cyc.delete();
    end else begin
      if (imem_rsp_valid) begin
        void'(pend_addr.pop_front());
        void'(pend_cyc.pop_front());
        model_out--;
      end
      if (PCSrcE) begin
        model_fetch = PCTargetE & 32'hFFFF_FFFC;
        exp_pc      = PCTargetE & 32'hFFFF_FFFC;
      end else begin
        if (hs) begin
          pend_addr.push_back(imem_req_addr);
          pend_cyc.push_back(cyc);
          model_fetch = model_fetch + 32'd4;
          model_out++;
        end
        if (pp) begin
          exp_pc = exp_pc + 32'd4;
          pops++;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; PCSrcE = 1'b0; StallD = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit found);
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      if (InstrValidD) found = 1;
      else cycle();
    end
    check32("wait_valid_timeout", 32'(found), 32'd1);
  endtask

  initial begin
    bit          found;
    int          first;
    logic [31:0] tgt;

    rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    PCSrcE = 1'b0; PCTargetE = '0; StallD = 1'b0;
    model_fetch = RESET_PC; exp_pc = RESET_PC; model_out = 0;
    @(negedge clk);

    // Streaming from reset: first valid instruction on the third cycle after release.
    do_reset();
    check32("reset_valid", 32'(InstrValidD), 32'd0);
    check32("reset_instr", InstrD, 32'h0000_0013);
    rsp_mode = 1;
    first = -1;
    for (int i = 0; i < 8; i++) begin
      if (InstrValidD && first < 0) first = i;
      cycle();
    end
    check32("first_valid_latency", 32'(first), 32'd2);

    // Backpressure fill.
    do_reset();
    StallD = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    check32("fill_req_stopped", 32'(imem_req_valid), 32'd0);
    check32("fill_head_pc", PCD, 32'h0);
    StallD = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      check32("drain_consecutive", 32'(InstrValidD), 32'd1);
      cycle();
    end

    // Redirect with two outstanding.
    do_reset();
    rsp_mode = 2; StallD = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    PCSrcE = 1'b1; PCTargetE = 32'h100;
    cycle();
    PCSrcE = 1'b0; StallD = 1'b0;
    check32("redirect_addr", imem_req_addr, 32'h100);
    rsp_mode = 1;
    wait_valid(20, found);
    check32("redirect_first_pc", PCD, 32'h100);
    check32("redirect_first_instr", InstrD, word(32'h100));

    // Redirect coincident with a response, then a second redirect before drops finish.
    do_reset();
    rsp_mode = 2; StallD = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    rsp_mode = 1; PCSrcE = 1'b1; PCTargetE = 32'h180;
    cycle();
    rsp_mode = 2; PCSrcE = 1'b0;
    cycle();
    PCSrcE = 1'b1; PCTargetE = 32'h200;
    cycle();
    PCSrcE = 1'b0; StallD = 1'b0; rsp_mode = 1;
    wait_valid(20, found);
    check32("double_redirect_pc", PCD, 32'h200);
    for (int i = 0; i < 6; i++) cycle();
    check32("drop_cnt_zero", 32'(dut.drop_cnt), 32'd0);

    // Misaligned target and address wrap.
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFE;
    cycle();
    PCSrcE = 1'b0;
    check32("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
    cycle();
    check32("wrap_addr1", imem_req_addr, 32'h0);
    wait_valid(20, found);
    check32("wrap_pcd", PCD, 32'hFFFF_FFFC);
    check32("wrap_pcplus4", PCPlus4D, 32'h0);

    // Reset mid-stream with entries buffered.
    StallD = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    check32("pre_reset_valid", 32'(InstrValidD), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0; StallD = 1'b0;
    check32("post_reset_valid", 32'(InstrValidD), 32'd0);
    check32("post_reset_instr", InstrD, 32'h0000_0013);
    check32("post_reset_addr", imem_req_addr, RESET_PC);

    // Random traffic.
    rsp_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 299) == 0);
      StallD         = ($urandom_range(0, 9) < 3);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      PCSrcE         = !rst && ($urandom_range(0, 19) == 0);
      tgt            = $urandom;
      PCTargetE      = tgt;
      cycle();
    end

    // Final drain must make forward progress.
    rst = 1'b0; StallD = 1'b0; PCSrcE = 1'b0; imem_req_ready = 1'b1; rsp_mode = 1;
    pops = 0;
    for (int i = 0; i < 20; i++) cycle();
    check32("final_progress", 32'(pops > 5), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction buffer entries; power of two, 2 to 16.
REQ-002 Parameter MAX_OUTSTANDING, default 2, maximum accepted but unanswered memory requests; 1 to DEPTH.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 imem_req_valid  output  1  fetch request valid.
REQ-007 imem_req_addr  output  32  fetch address; always equals internal fetch_pc.
REQ-008 imem_req_ready  input  1  memory accepts request; handshake = valid && ready.
REQ-009 imem_rsp_valid  input  1  instruction word returning, in request order, at least 1 cycle after handshake.
REQ-010 imem_rsp_data  input  32  returned instruction word.
REQ-011 PCSrcE  input  1  redirect from execute stage (taken branch/jump).
REQ-012 PCTargetE  input  32  redirect target.
REQ-013 StallD  input  1  decode cannot accept an instruction this cycle.
REQ-014 InstrValidD  output  1  InstrD/PCD/PCPlus4D hold a valid instruction.
REQ-015 InstrD, PCD, PCPlus4D  output  32 each  head-entry instruction, its PC, and PC+4.

Function
REQ-016 Request rule: imem_req_valid = !rst && !PCSrcE && (outstanding < MAX_OUTSTANDING) && (occupancy + outstanding < DEPTH).
REQ-017 On handshake: fetch_pc += 4 (mod 2^32, wraps at 32'hFFFF_FFFC to 0) and outstanding += 1.
REQ-018 rsp_pc tracks the PC of the next expected live response; it advances by 4 for each live response.
REQ-019 On imem_rsp_valid: outstanding -= 1. If drop_cnt > 0, discard the word and drop_cnt -= 1. Otherwise push {imem_rsp_data, rsp_pc} into the FIFO.
REQ-020 Pushed entries are visible at the outputs on the cycle after the push; there is no combinational rsp-to-output path.
REQ-021 When the FIFO is non-empty, InstrValidD = 1 and outputs show the head entry, with PCPlus4D = PCD + 4. When empty: InstrValidD = 0, InstrD = 32'h0000_0013 (NOP), PCD = 0, PCPlus4D = 0.
REQ-022 Pop when InstrValidD && !StallD; the next entry appears in the following cycle.
REQ-023 Simultaneous push and pop keeps occupancy unchanged. Push to a full FIFO cannot occur by construction (REQ-016); an assertion SHALL flag it.
REQ-024 Redirect (PCSrcE = 1) has priority over issue, push, and pop.
REQ-025 On redirect: FIFO emptied; fetch_pc and rsp_pc <= {PCTargetE[31:2], 2'b00}; drop_cnt <= outstanding minus 1 if imem_rsp_valid this cycle, else outstanding; outstanding updated per REQ-019.
REQ-026 A redirect while drop_cnt > 0 adds the newly pending count per REQ-025. No stale word SHALL ever reach the FIFO.
REQ-027 While StallD = 1 and no redirect, all outputs hold stable.
REQ-028 No request is issued in a redirect cycle. Fetching at the target begins the next cycle, subject to REQ-016.

Reset
REQ-029 While rst = 1 on a clock edge: fetch_pc = rsp_pc = RESET_PC; FIFO empty; outstanding = drop_cnt = 0. imem_req_valid is held 0 while rst is high.
REQ-030 Reset asserted mid-operation abandons all in-flight requests. Responses arriving during or after reset for pre-reset requests are outside the memory contract; the memory SHALL be reset in the same cycle.
REQ-031 Output values after reset are per REQ-021 (empty state).

Verification
REQ-032 Streaming: ready = 1, rsp 1 cycle after handshake, StallD = 0, words 0xA0..0xA5 -> InstrD sequence 0xA0.. with PCD 0x0, 0x4, ...; first InstrValidD 3 cycles after reset release.
REQ-033 Backpressure fill: StallD = 1 for 10 cycles -> exactly DEPTH = 4 entries buffered; requests stop; holds PCD = 0x0. Release -> 0x0, 0x4, 0x8, 0xC in consecutive cycles, no loss or duplication.
REQ-034 Redirect with 2 outstanding, PCTargetE = 0x100 -> both stale responses dropped; next valid PCD = 0x100 with the word for 0x100; imem_req_addr = 0x100 on the cycle after the redirect.
REQ-035 Redirect coincident with a response, plus a second redirect to 0x200 before drops finish -> only 0x200-stream instructions reach the outputs; drop_cnt returns to 0.
REQ-036 Misaligned/wrap: PCTargetE = 0xFFFF_FFFE -> fetch addresses 0xFFFF_FFFC, then 0x0000_0000. PCPlus4D = 0x0 for PCD = 0xFFFF_FFFC.
REQ-037 Reset mid-stream with 3 entries buffered -> next cycle InstrValidD = 0, InstrD = 0x13; imem_req_addr = RESET_PC after release.
